sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Controller that sequences serial-in/parallel-out capture.
- Gates bit shifting into an internal shift register and counts bits per frame.
- Presents each completed WIDTH-bit word to a downstream consumer with a valid/ready handshake, and flags bits that arrive while a word is still pending.
- Sits between a serial bit source and any parallel consumer in the design.

Parameters:
- WIDTH, 4, bits per frame / parallel word width; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in q[WIDTH-1]; 0: first received bit lands in q[0].

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- si  in  1  serial data bit.
- si_valid  in  1  si is sampled on this cycle.
- start  in  1  frame start strobe.
- out_ready  in  1  consumer accepts q this cycle.
- q  out  WIDTH  assembled parallel word.
- q_valid  out  1  q holds a complete word.
- busy  out  1  frame in progress (state SHIFT).
- bit_cnt  out  $clog2(WIDTH)+1  bits captured in the current frame.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset: rst_n=0 sampled on a rising edge of clk, synchronous and active-low, sets state=IDLE and clears q, q_valid, busy, bit_cnt, overrun and the shift register to 0. Reset mid-frame or mid-HOLD discards all data.
- Accepted bit: a cycle where si_valid=1 and the FSM is in SHIFT, or in IDLE with start=1.
- Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], si}.
- Shift, MSB_FIRST=0: sr <= {si, sr[WIDTH-1:1]}.
- IDLE:
  - start=1 -> SHIFT; bit_cnt <= 0.
  - If si_valid=1 in that same cycle, the bit is captured as bit 0 and bit_cnt <= 1.
  - si_valid without start is ignored; no overrun.
- SHIFT:
  - Each accepted bit increments bit_cnt.
  - On the accepted bit that brings the count to WIDTH: q <= next shift value, q_valid <= 1 on the next edge, state -> HOLD, bit_cnt <= 0.
  - Latency: q_valid rises 1 cycle after the final bit is sampled.
  - start=1 in SHIFT aborts the partial frame: bit_cnt restarts at 0, plus 1 if si_valid=1 that cycle. q and q_valid are unchanged.
  - busy=1 throughout SHIFT.
- HOLD:
  - q and q_valid=1 are held stable until out_ready=1.
  - Handshake completes on a cycle with q_valid=1 and out_ready=1; next edge: q_valid <= 0, state -> IDLE. q retains its value.
  - si_valid=1 in HOLD: bit dropped, overrun <= 1.
  - start=1 in HOLD is ignored.
  - si_valid and out_ready in the same cycle: transfer completes, bit still dropped, overrun set.
- overrun is sticky; it clears only on reset or on a start accepted in IDLE.
- out_ready has no effect while q_valid=0.
- bit_cnt never exceeds WIDTH-1 when observed outside the completing cycle. No wrap-around beyond WIDTH.

Decomposition:
- Package sipo_pkg:
  - state enum IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2.
  - function cnt_w(WIDTH) = $clog2(WIDTH)+1.
- One sub-module, sipo_shift_en: parameterised WIDTH/MSB_FIRST shift register with synchronous active-low reset and a shift enable. The FSM drives its enable with the accepted-bit term.

Test Plan:
1. WIDTH=4, MSB_FIRST=1: start with si_valid, bits 1,1,0,0 on consecutive cycles, out_ready=1 -> q=4'b1100, q_valid high exactly 1 cycle after the 4th bit, returns to IDLE, overrun=0.
2. Same stream with MSB_FIRST=0 -> q=4'b0011.
3. Bits 1,0,0,1 with si_valid gaps of 3 cycles between bits -> bit_cnt steps 1,2,3, then q=4'b1001; gaps add no extra bits.
4. Complete a word with out_ready=0 for 5 cycles and pulse si_valid during HOLD -> q stable at the completed value, overrun=1. Then out_ready=1 -> q_valid falls next cycle; overrun stays 1 until the next start.
5. Start, 2 bits (1,1), start again, then 4 bits 0,1,0,1 -> q=4'b0101; the aborted bits are lost.
6. rst_n=0 for 1 cycle after 3 bits captured -> all outputs 0 next cycle. A fresh frame 1,0,1,0 then yields q=4'b1010.

Source files
------------

// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller.
// Contents:
//   state_e - controller FSM states (IDLE, SHIFT, HOLD)
//   cnt_w   - width of the per-frame bit counter for a given word width
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Counter must be able to represent WIDTH itself, hence the extra bit.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Bus bundle between the serial source, the frame controller and the
// parallel consumer.
// Signals:
//   si, si_valid   - serial bit and its qualifier (source -> controller)
//   start          - frame start strobe (source -> controller)
//   out_ready      - consumer accepts q (consumer -> controller)
//   q, q_valid     - assembled word and its qualifier (controller -> consumer)
//   busy, bit_cnt  - frame-in-progress flag and captured-bit count
//   overrun        - sticky flag: bit arrived while a word was pending
// Modports: master drives the source/consumer side, slave is the controller.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    import sipo_pkg::*;

    logic                      si;
    logic                      si_valid;
    logic                      start;
    logic                      out_ready;
    logic [WIDTH-1:0]          q;
    logic                      q_valid;
    logic                      busy;
    logic [cnt_w(WIDTH)-1:0]   bit_cnt;
    logic                      overrun;

    modport master (
        output si, si_valid, start, out_ready,
        input  q, q_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  si, si_valid, start, out_ready,
        output q, q_valid, busy, bit_cnt, overrun
    );

endinterface

// File: rtl/sipo_shift_en.sv
// Enable-gated shift register used to assemble a serial word.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset, clears the register
//   en     - shift one bit in this cycle
//   si     - serial bit to shift in
//   sr_nxt - value the register takes if a shift happens this cycle
// MSB_FIRST=1 shifts towards the MSB so the first bit ends up in [WIDTH-1];
// MSB_FIRST=0 shifts towards the LSB so the first bit ends up in [0].
module sipo_shift_en #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             si,
    output logic [WIDTH-1:0] sr_nxt
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Shifted value and enable mux for the register.
    always_comb begin
        sr_nxt = sr_q;
        if (MSB_FIRST) begin
            sr_nxt = {sr_q[WIDTH-2:0], si};
        end else begin
            sr_nxt = {si, sr_q[WIDTH-1:1]};
        end
        if (en) begin
            sr_d = sr_nxt;
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= {WIDTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller.
// Gates bits into a shift register, counts WIDTH bits per frame, then holds
// the completed word on q with q_valid until the consumer takes it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset; discards any partial or held word
//   bus   - sipo_frame_ctrl_if.slave (si, si_valid, start, out_ready in;
//           q, q_valid, busy, bit_cnt, overrun out, all registered)
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    sipo_frame_ctrl_if.slave    bus
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              overrun_q, overrun_d;

    logic              accept_s;
    logic [WIDTH-1:0]  sr_nxt_s;

    // A bit is taken while shifting, or together with a start from IDLE.
    // A start in SHIFT with si_valid also shifts: the stale partial bits are
    // pushed out by the WIDTH bits of the new frame.
    always_comb begin
        accept_s = 1'b0;
        if (bus.si_valid && ((state_q == SHIFT) || ((state_q == IDLE) && bus.start))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    sipo_shift_en #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept_s),
        .si     (bus.si),
        .sr_nxt (sr_nxt_s)
    );

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        bit_cnt_d = bit_cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    bit_cnt_d = bus.si_valid ? CNT_ONE : CNT_ZERO;
                    overrun_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    bit_cnt_d = bus.si_valid ? CNT_ONE : CNT_ZERO;
                end else if (bus.si_valid) begin
                    if (bit_cnt_q == CNT_LAST) begin
                        q_d       = sr_nxt_s;
                        q_valid_d = 1'b1;
                        state_d   = HOLD;
                        bit_cnt_d = CNT_ZERO;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                // Incoming bits have nowhere to go while the word is pending.
                if (bus.si_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (bus.out_ready) begin
                    q_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d   = IDLE;
                q_valid_d = 1'b0;
                bit_cnt_d = CNT_ZERO;
            end
        endcase
        busy_d = (state_d == SHIFT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            q_q       <= {WIDTH{1'b0}};
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            bit_cnt_q <= CNT_ZERO;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy_q;
    assign bus.bit_cnt = bit_cnt_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench: one MSB-first and one LSB-first instance driven with
// the same stimulus; expected words are queued when the last bit is driven
// and checked (value and arrival cycle) when q_valid rises.
module tb_sipo_frame_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [3:0] exp_m[$];
    logic [3:0] exp_l[$];
    int         due_m[$];
    int         due_l[$];
    logic       qv_m_prev;
    logic       qv_l_prev;

    sipo_frame_ctrl_if #(.WIDTH(4)) if_m ();
    sipo_frame_ctrl_if #(.WIDTH(4)) if_l ();

    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Drive one cycle of inputs at the falling edge; return #1 after the
    // rising edge that sampled them. push queues an expected word whose
    // q_valid must appear right after that edge.
    task automatic step(input logic st, input logic sv, input logic b,
                        input logic rdy, input logic push, input logic [3:0] wm);
        @(negedge clk);
        if_m.start = st; if_m.si_valid = sv; if_m.si = b; if_m.out_ready = rdy;
        if_l.start = st; if_l.si_valid = sv; if_l.si = b; if_l.out_ready = rdy;
        if (push) begin
            exp_m.push_back(wm);
            exp_l.push_back(rev4(wm));
            due_m.push_back(cyc + 1);
            due_l.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    // Send a 4-bit frame, w[3] first, with gap idle cycles between bits.
    task automatic frame(input logic [3:0] w, input logic st_first, input int gap, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            step(st_first && (i == 0), 1'b1, w[3-i], rdy, (i == 3), w);
            if (i < 3) begin
                check_val("cnt_bit", if_m.bit_cnt, i + 1);
                check_val("busy_bit", if_m.busy, 1);
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 4'd0);
                    check_val("cnt_gap", if_m.bit_cnt, i + 1);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_q_m"}, if_m.q, 0);
        check_val({tag, "_qv_m"}, if_m.q_valid, 0);
        check_val({tag, "_busy_m"}, if_m.busy, 0);
        check_val({tag, "_cnt_m"}, if_m.bit_cnt, 0);
        check_val({tag, "_ovr_m"}, if_m.overrun, 0);
        check_val({tag, "_q_l"}, if_l.q, 0);
        check_val({tag, "_qv_l"}, if_l.q_valid, 0);
    endtask

    // Word monitor: on each rising q_valid compare against the scoreboard.
    initial begin
        qv_m_prev = 1'b0;
        qv_l_prev = 1'b0;
    end
    always @(negedge clk) begin
        if (rst_n && if_m.q_valid && !qv_m_prev) begin
            if (exp_m.size() == 0) begin
                check_val("m_unexpected", 1, 0);
            end else begin
                check_val("m_word", if_m.q, exp_m.pop_front());
                check_val("m_latency", cyc, due_m.pop_front());
            end
        end
        if (rst_n && if_l.q_valid && !qv_l_prev) begin
            if (exp_l.size() == 0) begin
                check_val("l_unexpected", 1, 0);
            end else begin
                check_val("l_word", if_l.q, exp_l.pop_front());
                check_val("l_latency", cyc, due_l.pop_front());
            end
        end
        qv_m_prev = if_m.q_valid;
        qv_l_prev = if_l.q_valid;
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_m.start = 1'b0; if_m.si_valid = 1'b0; if_m.si = 1'b0; if_m.out_ready = 1'b0;
        if_l.start = 1'b0; if_l.si_valid = 1'b0; if_l.si = 1'b0; if_l.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // si_valid without start in IDLE is ignored.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check_zero("idle_ign");

        // Tests 1/2: 1,1,0,0 back to back, consumer ready.
        frame(4'b1100, 1'b1, 0, 1'b1);
        check_val("t1_qv", if_m.q_valid, 1);
        check_val("t1_cnt", if_m.bit_cnt, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t1_qv_fall", if_m.q_valid, 0);
        check_val("t1_busy", if_m.busy, 0);
        check_val("t1_ovr", if_m.overrun, 0);
        check_val("t1_q_keep", if_m.q, 4'b1100);
        check_val("t2_q_keep", if_l.q, 4'b0011);

        // Test 3: 1,0,0,1 with 3-cycle gaps.
        frame(4'b1001, 1'b1, 3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t3_qv_fall", if_m.q_valid, 0);

        // Test 4: consumer stalls 5 cycles, bit arrives during HOLD.
        frame(4'b1011, 1'b1, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, (k == 1), 1'b1, 1'b0, 1'b0, 4'd0);
            check_val("t4_qv_hold", if_m.q_valid, 1);
            check_val("t4_q_hold", if_m.q, 4'b1011);
            check_val("t4_ql_hold", if_l.q, 4'b1101);
            check_val("t4_ovr", if_m.overrun, (k >= 1));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t4_qv_fall", if_m.q_valid, 0);
        check_val("t4_ovr_sticky", if_m.overrun, 1);
        check_val("t4_q_keep", if_m.q, 4'b1011);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t4_ovr_idle", if_m.overrun, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t4_ovr_clr", if_m.overrun, 0);
        check_val("t4_busy", if_m.busy, 1);
        check_val("t4_cnt0", if_m.bit_cnt, 0);

        // Test 5: partial 1,1 then restart with 0,1,0,1.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check_val("t5_cnt2", if_m.bit_cnt, 2);
        frame(4'b0101, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t5_qv_fall", if_m.q_valid, 0);

        // Test 6: reset after 3 bits, then fresh frame 1,0,1,0.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check_val("t6_cnt3", if_m.bit_cnt, 3);
        @(negedge clk);
        rst_n = 1'b0;
        if_m.si_valid = 1'b0; if_l.si_valid = 1'b0;
        if_m.start = 1'b0; if_l.start = 1'b0;
        @(posedge clk);
        #1;
        check_zero("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        frame(4'b1010, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("t6_qv_fall", if_m.q_valid, 0);

        // Drain: every queued word must have been seen.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("m_words_left", exp_m.size(), 0);
        check_val("l_words_left", exp_l.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
